spongent_permute: RTL and testbench

- Computes one round of a Spongent-style permutation over a 264-bit state.
- Per round, in order: counter XOR, then S-box layer, then bit-permutation layer (pLayer).
- Also advances the round counter LFSR (IV) and outputs its bit-reversed copy.
- An external controller chains rounds by feeding state_out, IV_out and INV_IV_out back into the inputs after rdy.

---
 rtl/spongent_permute_if.sv | 16 +
 rtl/spongent_permute.sv | 94 +++++++++
 tb/tb_spongent_permute.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/spongent_permute_if.sv
// spongent_permute_if: round request/result bundle between a round controller and spongent_permute
interface spongent_permute_if #(
  parameter int STATE_W = 264,
  parameter int IV_W    = 16
);
  logic               en;
  logic [STATE_W-1:0] state_in;
  logic [IV_W-1:0]    IV_in;
  logic [IV_W-1:0]    INV_IV_in;
  logic [STATE_W-1:0] state_out;
  logic [IV_W-1:0]    IV_out;
  logic [IV_W-1:0]    INV_IV_out;
  logic               rdy;
  modport master (output en, state_in, IV_in, INV_IV_in, input state_out, IV_out, INV_IV_out, rdy);
  modport slave  (input en, state_in, IV_in, INV_IV_in, output state_out, IV_out, INV_IV_out, rdy);
endinterface

// File: rtl/spongent_permute.sv
// spongent_permute: one Spongent round (counter XOR, S-box layer, pLayer) plus IV LFSR step; PERMUTE_PARALLEL_SBOX_EN selects a single-cycle S-box layer
module spongent_permute #(
  parameter int STATE_W = 264,
  parameter int IV_W    = 16
) (
  input logic clk,
  input logic rst,
  spongent_permute_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SBOX   = 3'd2;
  localparam logic [2:0] PLAYER = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [63:0] SBOX_LUT = 64'h63C958A7F4120BDE;
  localparam int NB = STATE_W / 8;
  localparam int CW = $clog2(NB);
  logic [2:0]         fsm;
  logic [STATE_W-1:0] st;
  logic [IV_W-1:0]    iv_nx;
`ifndef PERMUTE_PARALLEL_SBOX_EN
  logic [CW-1:0]      cnt;
`endif
  function automatic logic [3:0] sb(input logic [3:0] x);
    return SBOX_LUT[{x, 2'b00} +: 4];
  endfunction
  function automatic logic [IV_W-1:0] rev(input logic [IV_W-1:0] x);
    logic [IV_W-1:0] r;
    for (int i = 0; i < IV_W; i++) r[IV_W-1-i] = x[i];
    return r;
  endfunction
  function automatic logic [STATE_W-1:0] player(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] p;
    for (int j = 0; j < STATE_W - 1; j++) p[(j * (STATE_W / 4)) % (STATE_W - 1)] = s[j];
    p[STATE_W-1] = s[STATE_W-1];
    return p;
  endfunction
`ifdef PERMUTE_PARALLEL_SBOX_EN
  function automatic logic [STATE_W-1:0] sbox_all(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    for (int n = 0; n < STATE_W / 4; n++) r[4*n +: 4] = sb(s[4*n +: 4]);
    return r;
  endfunction
`endif
  // next LFSR counter: 8-bit shift-left with taps 7,5,4,3, upper byte zero
  assign iv_nx = {{(IV_W-8){1'b0}}, bus.IV_in[6:0], bus.IV_in[7] ^ bus.IV_in[5] ^ bus.IV_in[4] ^ bus.IV_in[3]};
  // round sequencer: inputs captured only in LOAD, results published in PLAYER, held through DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm            <= IDLE;
      st             <= '0;
      bus.state_out  <= '0;
      bus.IV_out     <= '0;
      bus.INV_IV_out <= '0;
      bus.rdy        <= 1'b0;
`ifndef PERMUTE_PARALLEL_SBOX_EN
      cnt            <= '0;
`endif
    end else begin
      case (fsm)
        IDLE: fsm <= bus.en ? LOAD : IDLE;
        LOAD: begin
          st             <= bus.state_in ^ {bus.INV_IV_in, {(STATE_W-2*IV_W){1'b0}}, bus.IV_in};
          bus.IV_out     <= iv_nx;
          bus.INV_IV_out <= rev(iv_nx);
          fsm            <= SBOX;
`ifndef PERMUTE_PARALLEL_SBOX_EN
          cnt            <= '0;
`endif
        end
        SBOX: begin
`ifdef PERMUTE_PARALLEL_SBOX_EN
          st  <= sbox_all(st);
          fsm <= PLAYER;
`else
          st[{cnt, 3'b000} +: 8] <= {sb(st[{cnt, 3'b100} +: 4]), sb(st[{cnt, 3'b000} +: 4])};
          cnt <= cnt + 1'b1;
          fsm <= (cnt == CW'(NB - 1)) ? PLAYER : SBOX;
`endif
        end
        PLAYER: begin
          bus.state_out <= player(st);
          bus.rdy       <= 1'b1;
          fsm           <= DONE;
        end
        DONE: begin
          bus.rdy <= bus.en;
          fsm     <= bus.en ? DONE : IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spongent_permute.sv
// tb_spongent_permute: randomized and directed checks of spongent_permute against a nibble/arithmetic reference model
module tb_spongent_permute;
`ifdef PERMUTE_PARALLEL_SBOX_EN
  localparam int LAT = 4;
  localparam int MID = 2;
`else
  localparam int LAT = 36;
  localparam int MID = 22;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int rises = 0;
  int sb_tab[16] = '{14, 13, 11, 0, 2, 1, 4, 15, 7, 10, 8, 5, 9, 12, 3, 6};
  spongent_permute_if bus();
  spongent_permute dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge bus.rdy) rises++;
  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [263:0] got, input logic [263:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic model_round(input logic [263:0] s, input logic [15:0] iv, input logic [15:0] inv,
                             output logic [263:0] so, output logic [15:0] io, output logic [15:0] ino);
    logic [263:0] a;
    int v;
    a = s;
    a[15:0] ^= iv;
    a[263:248] ^= inv;
    for (int n = 0; n < 66; n++) a[4*n +: 4] = 4'(sb_tab[a[4*n +: 4]]);
    for (int j = 0; j < 264; j++) so[(j == 263) ? 263 : (j * 66) % 263] = a[j];
    v = ((int'(iv[7:0]) * 2) % 256) + ((int'(iv[7]) + int'(iv[5]) + int'(iv[4]) + int'(iv[3])) % 2);
    io = 16'(v);
    for (int b = 0; b < 16; b++) ino[15-b] = io[b];
  endtask
  task automatic run_round(input logic [263:0] s, input logic [15:0] iv, input logic [15:0] inv, input bit hold,
                           output logic [263:0] so, output logic [15:0] io, output logic [15:0] ino);
    int lat;
    @(negedge clk);
    bus.state_in = s;
    bus.IV_in = iv;
    bus.INV_IV_in = inv;
    bus.en = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.rdy && lat < 200);
    chk("latency", 264'(lat), 264'(LAT));
    so = bus.state_out;
    io = bus.IV_out;
    ino = bus.INV_IV_out;
    if (!hold) begin
      bus.en = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic rand_state(output logic [263:0] s);
    for (int i = 0; i < 9; i++) s = {s[231:0], 32'($urandom)};
  endtask
  initial begin
    logic [263:0] s, so, ms, cs;
    logic [15:0] io, ino, miv, minv, civ, cinv, iv, inv;
    bus.en = 1'b1;
    bus.state_in = '0;
    bus.IV_in = '0;
    bus.INV_IV_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 264'(bus.rdy), 264'(0));
    chk("rst_state", bus.state_out, 264'(0));
    chk("rst_iv", 264'(bus.IV_out), 264'(0));
    chk("rst_inv", 264'(bus.INV_IV_out), 264'(0));
    bus.en = 1'b0;
    rst = 1'b1;
    run_round('0, 16'h0, 16'h0, 1'b1, so, io, ino);
    ms = '1;
    ms[65:0] = '0;
    chk("zero_state", so, ms);
    chk("zero_iv", 264'(io), 264'(0));
    chk("zero_inv", 264'(ino), 264'(0));
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("hold_rdy", 264'(bus.rdy), 264'(1));
      chk("hold_state", bus.state_out, ms);
    end
    bus.en = 1'b0;
    @(negedge clk);
    chk("drop_rdy", 264'(bus.rdy), 264'(0));
    run_round('0, 16'h00C6, 16'h0, 1'b0, so, io, ino);
    model_round('0, 16'h00C6, 16'h0, ms, miv, minv);
    chk("c6_iv", 264'(io), 264'(16'h008D));
    chk("c6_inv", 264'(ino), 264'(16'hB100));
    chk("c6_state", so, ms);
    for (int r = 0; r < 8; r++) begin
      rand_state(s);
      iv = 16'($urandom);
      inv = 16'($urandom);
      run_round(s, iv, inv, 1'b0, so, io, ino);
      model_round(s, iv, inv, ms, miv, minv);
      chk("rnd_state", so, ms);
      chk("rnd_iv", 264'(io), 264'(miv));
      chk("rnd_inv", 264'(ino), 264'(minv));
    end
    rand_state(s);
    iv = 16'($urandom);
    inv = 16'($urandom);
    @(negedge clk);
    bus.state_in = s;
    bus.IV_in = iv;
    bus.INV_IV_in = inv;
    bus.en = 1'b1;
    repeat (MID) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rdy", 264'(bus.rdy), 264'(0));
    chk("mid_state", bus.state_out, 264'(0));
    chk("mid_iv", 264'(bus.IV_out), 264'(0));
    chk("mid_inv", 264'(bus.INV_IV_out), 264'(0));
    @(negedge clk);
    bus.en = 1'b0;
    rst = 1'b1;
    run_round(s, iv, inv, 1'b0, so, io, ino);
    model_round(s, iv, inv, ms, miv, minv);
    chk("mid_rerun_state", so, ms);
    chk("mid_rerun_iv", 264'(io), 264'(miv));
    for (int i = 0; i < 33; i++) cs[8*i +: 8] = 8'(i);
    civ = 16'h00C6;
    cinv = 16'h0;
    ms = cs;
    miv = civ;
    minv = cinv;
    rises = 0;
    for (int r = 0; r < 135; r++) begin
      run_round(cs, civ, cinv, 1'b0, cs, civ, cinv);
      model_round(ms, miv, minv, ms, miv, minv);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
    chk("chain_state", cs, ms);
    chk("chain_iv", 264'(civ), 264'(miv));
    chk("chain_inv", 264'(cinv), 264'(minv));
    chk("chain_rdy_count", 264'(rises), 264'(135));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
